// File: rtl/instr_align_queue.sv
// instr_align_queue: fetch word queue plus RVC aligner feeding decode.
// Buffers fetched 32-bit words and presents one 16- or 32-bit instruction
// per cycle, including 32-bit instructions that straddle two words.
module instr_align_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [XLEN-1:0]            flush_pc,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [XLEN-1:0]            fetch_addr,
    input  logic [31:0]                fetch_data,
    input  logic                       fetch_error,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [XLEN-1:0]            dec_pc,
    output logic [XLEN-1:0]            dec_npc,
    output logic [31:0]                dec_instr,
    output logic                       dec_error,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]     mem_data [DEPTH];
    logic            mem_err  [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ea;

    logic [31:0]     w0;
    logic [15:0]     w1_lo;
    logic            e0;
    logic            e1;
    logic            hoff;
    logic            is32;
    logic            pop;
    logic            consume;
    logic            do_pop;
    logic            push;

    // Head word, the low half of the word behind it, and their fault flags.
    assign w0    = mem_data[head];
    assign e0    = mem_err[head];
    assign w1_lo = mem_data[head + PW'(1)][15:0];
    assign e1    = mem_err[head + PW'(1)];
    assign hoff  = pc[1];

    assign count       = count_q;
    assign dec_pc      = pc;
    assign fetch_ready = (count_q < DEPTH_C);

    // Only the word at the expected address is queued; anything else is a
    // stale fetch from before a redirect and is silently swallowed.
    assign push = fetch_valid & fetch_ready & (fetch_addr == ea) & ~flush;

    // Decode the instruction starting at the current halfword of the head word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dec_valid = 1'b0;
        dec_error = 1'b0;
        dec_instr = '0;
        pop       = 1'b0;
        is32      = hoff ? (w0[17:16] == 2'b11) : (w0[1:0] == 2'b11);
        if (count_q != '0) begin
            if (e0) begin
                // Faulted head word: report it and wait for a redirect.
                dec_valid = 1'b1;
                dec_error = 1'b1;
            end else if (!hoff) begin
                dec_valid = 1'b1;
                dec_instr = is32 ? w0 : {16'h0000, w0[15:0]};
                pop       = is32;
            end else if (!is32) begin
                dec_valid = 1'b1;
                dec_instr = {16'h0000, w0[31:16]};
                pop       = 1'b1;
            end else if (count_q >= CW'(2)) begin
                // Straddling 32-bit instruction needs the following word too.
                dec_valid = 1'b1;
                dec_error = e1;
                dec_instr = {w1_lo, w0[31:16]};
                pop       = 1'b1;
            end
        end
        dec_npc = pc + (is32 ? XLEN'(4) : XLEN'(2));
    end

    // A faulted instruction is never consumed, so it stays until flush.
    assign consume = dec_valid & dec_ready & ~dec_error;
    assign do_pop  = consume & pop;

    // Pointer, count, pc and expected-address registers; flush wins over traffic.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            pc      <= RESET_PC;
            ea      <= {RESET_PC[XLEN-1:2], 2'b00};
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            pc      <= flush_pc;
            ea      <= {flush_pc[XLEN-1:2], 2'b00};
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                ea   <= ea + XLEN'(4);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            if (consume) begin
                pc <= dec_npc;
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Word storage written at the tail on an accepted in-order fetch.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count and pointers alone decide what is valid.
        if (push) begin
            mem_data[tail] <= fetch_data;
            mem_err[tail]  <= fetch_error;
        end
    end

endmodule

// File: tb/tb_instr_align_queue.sv
// tb_instr_align_queue: directed plus randomized check of the aligner against
// a halfword-stream reference model held in a queue of fetched words.
module tb_instr_align_queue;

    localparam int          DEPTH  = 4;
    localparam int          XLEN   = 32;
    localparam int          CW     = $clog2(DEPTH+1);
    localparam logic [31:0] RST_PC = 32'h80;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_addr;
    logic [31:0]     fetch_data;
    logic            fetch_error;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_npc;
    logic [31:0]     dec_instr;
    logic            dec_error;
    logic [CW-1:0]   count;

    instr_align_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_error (fetch_error),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_npc     (dec_npc),
        .dec_instr   (dec_instr),
        .dec_error   (dec_error),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
    } word_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] instr;
        logic [2:0]  len;
        logic [1:0]  pops;
    } exp_t;

    word_t       mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ea;

    // Halfword k of the queued instruction stream (k=0 is low half of head word).
    function automatic logic [15:0] hw(input int k);
        word_t w;
        w = mq[k / 2];
        return (k % 2 == 1) ? w.data[31:16] : w.data[15:0];
    endfunction

    function automatic exp_t model_eval();
        exp_t        r;
        int          h;
        int          need;
        logic [15:0] lo;
        r = '0;
        h = int'(m_pc[1]);
        if (mq.size() == 0) return r;
        lo    = hw(h);
        r.len = (lo[1:0] == 2'b11) ? 3'd4 : 3'd2;
        if (mq[0].err) begin
            r.valid = 1'b1;
            r.err   = 1'b1;
            return r;
        end
        need = (2 * h + int'(r.len) + 3) / 4;
        if (mq.size() < need) return r;
        r.valid = 1'b1;
        for (int i = 0; i < need; i++) r.err = r.err | mq[i].err;
        r.instr = (r.len == 3'd4) ? {hw(h + 1), lo} : {16'h0000, lo};
        r.pops  = 2'((2 * h + int'(r.len)) / 4);
        return r;
    endfunction

    // Model state update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        exp_t r;
        bit   acc;
        if (rst) begin
            mq.delete();
            m_pc = RST_PC;
            m_ea = RST_PC & ~32'h3;
        end else if (flush) begin
            mq.delete();
            m_pc = flush_pc;
            m_ea = flush_pc & ~32'h3;
        end else begin
            r   = model_eval();
            acc = fetch_valid && (mq.size() < DEPTH);
            if (r.valid && dec_ready && !r.err) begin
                repeat (int'(r.pops)) void'(mq.pop_front());
                m_pc = m_pc + 32'(r.len);
            end
            if (acc && fetch_addr == m_ea) begin
                mq.push_back('{fetch_data, fetch_error});
                m_ea = m_ea + 32'h4;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t r;
        if (cmp_en) begin
            r = model_eval();
            check("fetch_ready", 64'(fetch_ready), 64'(mq.size() < DEPTH));
            check("count", 64'(count), 64'(mq.size()));
            check("dec_valid", 64'(dec_valid), 64'(r.valid));
            check("dec_error", 64'(dec_error), 64'(r.err));
            check("dec_pc", 64'(dec_pc), 64'(m_pc));
            if (r.valid) begin
                check("dec_npc", 64'(dec_npc), 64'(m_pc + 32'(r.len)));
                check("dec_instr", 64'(dec_instr), 64'(r.instr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic fv, input logic [31:0] a, input logic [31:0] d,
                       input logic e, input logic r, input logic f, input logic [31:0] fp);
        fetch_valid = fv;
        fetch_addr  = a;
        fetch_data  = d;
        fetch_error = e;
        dec_ready   = r;
        flush       = f;
        flush_pc    = fp;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, r, 1'b0, 32'h0);
    endtask

    initial begin
        logic        fv, e, r, f;
        logic [31:0] a, d, fp;
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0; fetch_error = 1'b0;
        dec_ready = 1'b0; flush = 1'b0; flush_pc = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Reset state.
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(dec_valid), 64'd0);
        check("rst_error", 64'(dec_error), 64'd0);
        check("rst_fready", 64'(fetch_ready), 64'd1);
        check("rst_pc", 64'(dec_pc), 64'h80);

        // Two 32-bit words from the reset pc.
        cyc(1'b1, 32'h80, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);
        check("w32a_pc", 64'(dec_pc), 64'h80);
        check("w32a_npc", 64'(dec_npc), 64'h84);
        check("w32a_instr", 64'(dec_instr), 64'h00000013);
        cyc(1'b1, 32'h84, 32'h00100093, 1'b0, 1'b1, 1'b0, 32'h0);
        check("w32b_pc", 64'(dec_pc), 64'h84);
        check("w32b_npc", 64'(dec_npc), 64'h88);
        check("w32b_instr", 64'(dec_instr), 64'h00100093);
        idle(1'b1);
        check("w32_drain", 64'(count), 64'd0);

        // Two compressed instructions from one word, one pop.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b1, 32'h0, 32'h45014501, 1'b0, 1'b0, 1'b0, 32'h0);
        check("c2a_instr", 64'(dec_instr), 64'h4501);
        check("c2a_pc", 64'(dec_pc), 64'h0);
        idle(1'b1);
        check("c2b_pc", 64'(dec_pc), 64'h2);
        check("c2b_instr", 64'(dec_instr), 64'h4501);
        check("c2b_count", 64'(count), 64'd1);
        idle(1'b1);
        check("c2_pop", 64'(count), 64'd0);

        // Straddling 32-bit instruction.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b1, 32'h0, 32'h00134501, 1'b0, 1'b0, 1'b0, 32'h0);
        check("st_c_instr", 64'(dec_instr), 64'h4501);
        idle(1'b1);
        check("st_wait_valid", 64'(dec_valid), 64'd0);
        check("st_wait_pc", 64'(dec_pc), 64'h2);
        idle(1'b1);
        check("st_hold_valid", 64'(dec_valid), 64'd0);
        cyc(1'b1, 32'h4, 32'h12340000, 1'b0, 1'b0, 1'b0, 32'h0);
        check("st_valid", 64'(dec_valid), 64'd1);
        check("st_instr", 64'(dec_instr), 64'h00000013);
        check("st_npc", 64'(dec_npc), 64'h6);
        idle(1'b1);
        check("st_next_pc", 64'(dec_pc), 64'h6);
        check("st_next_instr", 64'(dec_instr), 64'h1234);
        idle(1'b1);

        // Fill to DEPTH, then a pop while a push is refused.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 32'h200 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_fready", 64'(fetch_ready), 64'd0);
        cyc(1'b1, 32'h210, 32'h00000013, 1'b0, 1'b1, 1'b0, 32'h0);
        check("full_pop_count", 64'(count), 64'(DEPTH - 1));
        check("full_pop_fready", 64'(fetch_ready), 64'd1);

        // Redirect with stale fetches in flight.
        cyc(1'b1, 32'h10, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h102);
        cyc(1'b1, 32'h14, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stale_count", 64'(count), 64'd0);
        cyc(1'b1, 32'h100, 32'hABCD0001, 1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_count", 64'(count), 64'd1);
        check("redir_pc", 64'(dec_pc), 64'h102);
        check("redir_instr", 64'(dec_instr), 64'h0000ABCD);
        check("redir_npc", 64'(dec_npc), 64'h104);

        // Fetch fault held until flush.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20);
        cyc(1'b1, 32'h20, 32'h00000013, 1'b1, 1'b0, 1'b0, 32'h0);
        check("err_valid", 64'(dec_valid), 64'd1);
        check("err_error", 64'(dec_error), 64'd1);
        check("err_pc", 64'(dec_pc), 64'h20);
        check("err_instr", 64'(dec_instr), 64'h0);
        idle(1'b1);
        idle(1'b1);
        check("err_held", 64'(dec_valid & dec_error), 64'd1);
        check("err_held_count", 64'(count), 64'd1);
        cyc(1'b1, 32'h20, 32'h00000013, 1'b0, 1'b1, 1'b1, 32'h20);
        check("flush_enq_count", 64'(count), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            fv = ($urandom_range(0, 9) < 7);
            a  = ($urandom_range(0, 9) == 0) ? (m_ea ^ 32'h40) : m_ea;
            d  = $urandom;
            e  = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 49) == 0);
            fp = 32'($urandom_range(0, 1023)) << 1;
            cyc(fv, a, d, e, r, f, fp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_align_queue.md
# instr_align_queue

Parametrised instruction buffer and RVC aligner between the fetch stage and `decode_stage`. It queues fetched 32-bit words and extracts one 16-bit or 32-bit instruction per cycle, including 32-bit instructions that straddle a word boundary. It supplies the instruction's pc and npc, drops stale fetches after a redirect, and replaces the fixed `pc + 2/4` handling in decode with a buffered front end.

## Interface
Parameters:
- `DEPTH`, 4: number of queued fetch words; a power of two, at least 2.
- `XLEN`, 32: pc and address width.
- `RESET_PC`, 0: pc after reset; must be halfword aligned.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: redirect request (jump, exception or mret clear from decode/execute).
- `flush_pc` in XLEN: redirect target; halfword aligned.
- `fetch_valid` in 1: fetch word present.
- `fetch_ready` out 1: block accepts a fetch word this cycle.
- `fetch_addr` in XLEN: word-aligned address of `fetch_data`.
- `fetch_data` in 32: fetched word.
- `fetch_error` in 1: access fault on this word.
- `dec_valid` out 1: an instruction is presented to decode.
- `dec_ready` in 1: decode consumes the instruction (decode not stalled).
- `dec_pc` out XLEN: pc of the presented instruction.
- `dec_npc` out XLEN: `dec_pc` + 2 or + 4.
- `dec_instr` out 32: the instruction; a 16-bit instruction is zero-extended to 32 bits.
- `dec_error` out 1: the instruction fetch faulted.
- `count` out clog2(DEPTH+1): number of occupied word entries.

## Operation
State:
- circular word queue: data, address and error flag per entry.
- head/tail pointers and `count`.
- `pc` register.
- `hoff`: halfword offset in the head word; equals `pc[1]`.
- `ea`: expected enqueue word address.

Enqueue:
- `fetch_ready` = (count < DEPTH).
- Accept when `fetch_valid & fetch_ready`.
- If `fetch_addr == ea`: write the entry at the tail and set `ea += 4`.
- Otherwise the word is stale: consume and discard it, with no state change.

Extraction (combinational, from head word W0 and next word W1):
- hoff=0, W0[1:0]!=2'b11: 16-bit instruction W0[15:0]. Needs count>=1. On consume: hoff becomes 1, no pop.
- hoff=0, W0[1:0]==2'b11: 32-bit instruction W0. Needs count>=1. On consume: pop 1 word, hoff stays 0.
- hoff=1, W0[17:16]!=2'b11: 16-bit instruction W0[31:16]. Needs count>=1. On consume: pop 1 word, hoff becomes 0.
- hoff=1, W0[17:16]==2'b11: 32-bit instruction {W1[15:0], W0[31:16]}. Needs count>=2. On consume: pop 1 word (W0), hoff stays 1.

Valid, error and pc:
- `dec_valid` = the required word count is present.
- `dec_error` = OR of the error flags of the words the instruction uses.
- If W0 has its error flag set, `dec_valid`=1 and `dec_error`=1 regardless of length, with `dec_instr`=0.
- An error instruction is never consumed; it is held until `flush`.
- On the `dec_valid & dec_ready` handshake, `pc` advances by the instruction length (2 or 4); XLEN arithmetic wraps modulo 2^XLEN.

Flush:
- Empties the queue and sets count=0.
- Sets pc=flush_pc, hoff=flush_pc[1], ea={flush_pc[XLEN-1:2],2'b00}.
- Has priority over enqueue and dequeue in the same cycle; the fetch word presented that cycle is discarded.

Reset:
- Same effect as a flush to `RESET_PC`.
- Output values after reset: count=0, dec_valid=0, dec_error=0, fetch_ready=1, dec_pc=RESET_PC.

## Timing
- Fetch-to-decode latency: a word accepted in cycle N can be presented as `dec_valid` in cycle N+1. There is no combinational path from `fetch_*` to `dec_*`.
- Throughput: one instruction per cycle when decode is ready and the queue is non-empty. Two 16-bit instructions come from one word in consecutive cycles.
- Push and pop in the same cycle are allowed; count changes by push minus pop.
- When full, `fetch_ready` is 0 even if a pop happens that cycle; it is computed from registered count only.
- A straddling 32-bit instruction with count=1 gives `dec_valid`=0 until the next word arrives.
- `dec_ready` while `dec_valid`=0 has no effect.
- All outputs are stable within the cycle and depend only on registered state, except `fetch_ready`, which is registered-only by construction.

## Test plan
- Reset with RESET_PC=0x80, push words 0x00000013, 0x00100093 at 0x80 and 0x84 -> dec_pc 0x80 then 0x84, dec_npc 0x84 then 0x88, dec_instr equal to each word.
- Word 0x45014501 at 0x0 (two c.li) -> two instructions: 0x00004501 at pc 0x0, then 0x00004501 at pc 0x2; one pop.
- Word 0x00134501 at 0x0, then 0x12340000 at 0x4 -> 0x4501 at pc 0x0, then straddle instruction 0x00000013 at pc 0x2 with npc 0x6 and dec_valid=0 until the second word is queued; the next instruction is at pc 0x6 from the upper half of word 0x4.
- Fill DEPTH words with dec_ready=0 -> fetch_ready=0 and count=DEPTH. Raise dec_ready with a 32-bit head -> pop, and fetch_ready returns to 1 the next cycle.
- Flush to 0x102 while stale words at 0x10, 0x14 and a valid word at 0x100 arrive -> stale words dropped, word 0x100 queued, first dec_pc=0x102 using the upper half of word 0x100.
- Word at 0x20 with fetch_error=1 -> dec_valid=1, dec_error=1, dec_pc=0x20, held across dec_ready=1 until flush; flush with a simultaneous enqueue leaves count=0.
